// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK receive path: default packet width and
// the bit-order enum that both the assembler and the UART side agree on.
package bpsk_pkg;

    localparam int DEFAULT_PACKET_SIZE = 8;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } bit_order_e;

    // Index in the packet word where the count-th received bit lands.
    function automatic int bit_position(input bit_order_e order, input int size, input int count);
        return (order == ORDER_MSB_FIRST) ? (size - 1 - count) : count;
    endfunction

endpackage

// File: rtl/pkt_hold_reg.sv
// Single-entry valid/ready holding register.
// Handshake: a word moves to the consumer at a rising edge where valid and
// ready are both high; data/valid stay frozen while valid=1 and ready=0;
// ready is ignored while valid=0. The producer may only pulse load when
// can_load is high; a load in the same cycle as a pop replaces the word
// with no bubble.
module pkt_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         can_load
);

    // Room for a new word when empty or when the current word leaves this edge.
    assign can_load = !valid || ready;

    // Hold register: load wins over pop; pop alone empties the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// Serial-to-parallel packet builder: demodulated bits are collected into an
// assembly register (stage A) and handed to a holding register (stage B)
// that presents them to the UART over valid/ready. Dropped bits raise a
// sticky overflow flag.
module packet_assembler
    import bpsk_pkg::*;
#(
    parameter int PACKET_SIZE = DEFAULT_PACKET_SIZE,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int CNT_W       = $clog2(PACKET_SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    input  logic                   flush,
    output logic [PACKET_SIZE-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [CNT_W-1:0]       bit_count,
    output logic                   overflow,
    input  logic                   ovf_clear
);

    localparam bit_order_e       ORDER      = MSB_FIRST ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(PACKET_SIZE);

    logic [PACKET_SIZE-1:0] asm_reg;
    logic [PACKET_SIZE-1:0] asm_next;
    logic [CNT_W-1:0]       count;
    logic                   a_full;
    logic                   can_load;
    logic                   accept;
    logic                   drop;
    logic                   transfer;

    // A full stage A refuses bits until its packet moves to stage B; a
    // transfer cycle never also accepts a bit. flush overrides everything in A.
    assign a_full   = (count == FULL_COUNT);
    assign accept   = bit_valid && !a_full && !flush;
    assign drop     = bit_valid &&  a_full && !flush;
    assign transfer = a_full && can_load && !flush;

    // Assembly word with the incoming bit placed at its ordered position.
    always_comb begin
        asm_next = asm_reg;
        for (int i = 0; i < PACKET_SIZE; i++) begin
            if (i == bit_position(ORDER, PACKET_SIZE, int'(count))) begin
                asm_next[i] = bit_in;
            end
        end
    end

    // Stage A: assembly register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_reg <= '0;
            count   <= '0;
        end else if (flush) begin
            asm_reg <= '0;
            count   <= '0;
        end else if (transfer) begin
            asm_reg <= '0;
            count   <= '0;
        end else if (accept) begin
            asm_reg <= asm_next;
            count   <= count + 1'b1;
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    pkt_hold_reg #(
        .W (PACKET_SIZE)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (transfer),
        .load_data (asm_reg),
        .ready     (pkt_ready),
        .data      (pkt_data),
        .valid     (pkt_valid),
        .can_load  (can_load)
    );

    assign bit_count = count;

endmodule

// File: tb/tb_packet_assembler.sv
// Bench for packet_assembler: two instances (MSB-first and LSB-first) share
// one stimulus stream and are compared every cycle against a queue-based
// model of the packet builder, plus directed literal expectations.
module tb_packet_assembler;

    localparam int PS    = 8;
    localparam int CNT_W = $clog2(PS + 1);

    logic             clk;
    logic             rst_n;
    logic             bit_valid;
    logic             bit_in;
    logic             flush;
    logic             pkt_ready;
    logic             ovf_clear;

    logic [PS-1:0]    m_data;
    logic             m_valid;
    logic [CNT_W-1:0] m_count;
    logic             m_ovf;
    logic [PS-1:0]    l_data;
    logic             l_valid;
    logic [CNT_W-1:0] l_count;
    logic             l_ovf;

    int checks;
    int failures;
    bit cmp_en;

    // Model state: bits waiting in stage A in arrival order, stage B contents.
    bit            a_q[$];
    bit            b_valid_m;
    logic [PS-1:0] b_msb_m;
    logic [PS-1:0] b_lsb_m;
    bit            ovf_m;

    packet_assembler #(.PACKET_SIZE(PS), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .flush     (flush),
        .pkt_data  (m_data),
        .pkt_valid (m_valid),
        .pkt_ready (pkt_ready),
        .bit_count (m_count),
        .overflow  (m_ovf),
        .ovf_clear (ovf_clear)
    );

    packet_assembler #(.PACKET_SIZE(PS), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .flush     (flush),
        .pkt_data  (l_data),
        .pkt_valid (l_valid),
        .pkt_ready (pkt_ready),
        .bit_count (l_count),
        .overflow  (l_ovf),
        .ovf_clear (ovf_clear)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PS-1:0] rev(input logic [PS-1:0] v);
        logic [PS-1:0] r;
        for (int k = 0; k < PS; k++) r[PS-1-k] = v[k];
        return r;
    endfunction

    task automatic model_reset();
        a_q.delete();
        b_valid_m = 1'b0;
        b_msb_m   = '0;
        b_lsb_m   = '0;
        ovf_m     = 1'b0;
    endtask

    // One clock edge of the packet builder as seen from outside.
    task automatic model_step(input bit bv, input bit bi, input bit fl, input bit rdy, input bit oc);
        bit            full;
        bit            xfer;
        bit            pop;
        logic [PS-1:0] arrival;
        full = (a_q.size() == PS);
        xfer = full && (!b_valid_m || rdy) && !fl;
        pop  = b_valid_m && rdy && !xfer;
        if (bv && full && !fl) ovf_m = 1'b1;
        else if (oc)           ovf_m = 1'b0;
        if (fl) begin
            a_q.delete();
        end else if (xfer) begin
            arrival = '0;
            for (int k = 0; k < PS; k++) arrival[k] = a_q[k];
            b_lsb_m   = arrival;
            b_msb_m   = rev(arrival);
            b_valid_m = 1'b1;
            a_q.delete();
        end else if (bv && !full) begin
            a_q.push_back(bi);
        end
        if (pop) b_valid_m = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at the next falling edge.
    task automatic step(input bit bv, input bit bi, input bit fl, input bit rdy, input bit oc);
        bit_valid = bv;
        bit_in    = bi;
        flush     = fl;
        pkt_ready = rdy;
        ovf_clear = oc;
        @(posedge clk);
        model_step(bv, bi, fl, rdy, oc);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit rdy);
        for (int i = 7; i >= 0; i--) step(1'b1, v[i], 1'b0, rdy, 1'b0);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("msb_data",  m_data,  b_msb_m);
            check("msb_valid", m_valid, b_valid_m);
            check("msb_count", m_count, a_q.size());
            check("msb_ovf",   m_ovf,   ovf_m);
            check("lsb_data",  l_data,  b_lsb_m);
            check("lsb_valid", l_valid, b_valid_m);
            check("lsb_count", l_count, a_q.size());
            check("lsb_ovf",   l_ovf,   ovf_m);
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        cmp_en    = 1'b0;
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        flush     = 1'b0;
        pkt_ready = 1'b0;
        ovf_clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_data",  m_data,  0);
        check("rst_valid", m_valid, 0);
        check("rst_count", m_count, 0);
        check("rst_ovf",   m_ovf,   0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Basic packet, both bit orders, latency of one edge after the last bit.
        for (int i = 7; i >= 1; i--) step(1'b1, i[0] ? 1'b0 : 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        begin
            logic [7:0] pat;
            pat = 8'hB2;
            for (int i = 7; i >= 1; i--) step(1'b1, pat[i], 1'b0, 1'b1, 1'b0);
            step(1'b1, pat[0], 1'b0, 1'b1, 1'b0);
        end
        check("t1_count_full", m_count, 8);
        check("t1_valid_wait", m_valid, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_msb_data",  m_data,  8'hB2);
        check("t1_lsb_data",  l_data,  8'h4D);
        check("t1_valid",     m_valid, 1);
        check("t1_count_0",   m_count, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_consumed",  m_valid, 0);

        // Back-pressure: two packets stored, third bit dropped, no-gap replacement.
        send_byte(8'hA5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0);
        check("t3_hold_data", m_data,  8'hA5);
        check("t3_count8",    m_count, 8);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_ovf",       m_ovf,   1);
        check("t3_still_a5",  m_data,  8'hA5);
        check("t3_still_cnt", m_count, 8);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_next_data", m_data,  8'h3C);
        check("t3_next_valid", m_valid, 1);
        check("t3_next_cnt",  m_count, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_empty",     m_valid, 0);

        // Flush beats a simultaneous bit; next packet is clean.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t4_ovf_clr",   m_ovf, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t4_count5",    m_count, 5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t4_flush_cnt", m_count, 0);
        check("t4_flush_ovf", m_ovf,   0);
        send_byte(8'h6E, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_msb_data",  m_data, 8'h6E);
        check("t4_lsb_data",  l_data, 8'h76);

        // Overflow set wins over a same-cycle clear.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(8'h11, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_ovf_set",   m_ovf, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_set_wins",  m_ovf, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_cleared",   m_ovf, 0);

        // Flush leaves stage B alone; then async reset mid-packet.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_b_kept",    m_valid, 1);
        check("t5_b_data",    m_data,  8'h11);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_count",     m_count, 5);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_count4",    m_count, 4);
        bit_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_rst_data",  m_data,  0);
        check("t5_rst_valid", m_valid, 0);
        check("t5_rst_count", m_count, 0);
        check("t5_rst_ovf",   m_ovf,   0);
        check("t5_rst_lsb",   l_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            step(($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 6));
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
